// File: rtl/blink_cursor_ctrl.sv
// blink_cursor_ctrl: edit-mode cursor selection with a blinking cursor digit
module blink_cursor_ctrl #(
   parameter int NUM_DIGITS = 4,
   parameter int TICK_DIV   = 25000000
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          editEn,
   input  logic                          btnNext,
   input  logic                          btnPrev,
   input  logic                          btnInc,
   output logic [NUM_DIGITS-1:0]         isOn,
   output logic [$clog2(NUM_DIGITS)-1:0] cursor,
   output logic                          editing
);
   localparam int CW = $clog2(NUM_DIGITS);
   localparam int TW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] CMAX = CW'(NUM_DIGITS - 1);
   localparam logic [TW-1:0] TMAX = TW'(TICK_DIV - 1);
   typedef enum logic {IDLE, EDIT} state_t;
   state_t state, state_nx;
   logic [CW-1:0] cursor_nx;
   logic [TW-1:0] cnt, cnt_nx;
   logic phase, phase_nx;
   logic btn_any;
   assign btn_any = btnNext | btnPrev | btnInc;
   // state register; reset returns to idle with the cursor digit visible
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cursor <= '0;
         cnt    <= '0;
         phase  <= 1'b1;
      end else begin
         state  <= state_nx;
         cursor <= cursor_nx;
         cnt    <= cnt_nx;
         phase  <= phase_nx;
      end
   end
   // next state; anything other than staying in edit parks cursor/cnt/phase at idle values
   always_comb begin
      state_nx  = editEn ? EDIT : IDLE;
      cursor_nx = '0;
      cnt_nx    = '0;
      phase_nx  = 1'b1;
      if (state == EDIT && editEn) begin
         cursor_nx = (btnNext && !btnPrev) ? ((cursor == CMAX) ? '0 : cursor + 1'b1) :
                     (btnPrev && !btnNext) ? ((cursor == '0) ? CMAX : cursor - 1'b1) : cursor;
         cnt_nx    = (btn_any || cnt == TMAX) ? '0 : cnt + 1'b1;
         phase_nx  = btn_any ? 1'b1 : (cnt == TMAX) ? ~phase : phase;
      end
   end
   // digit enables decoded from registered state only
   always_comb begin
      isOn = '1;
      if (state == EDIT) isOn[cursor] = phase;
   end
   assign editing = (state == EDIT);
endmodule
